// File: rtl/ram_stream_ctrl.sv
// ram_stream_ctrl: command-driven burst engine streaming bytes into and out of a single-port RAM.
module ram_stream_ctrl #(
  parameter int ADDR_BITS = 6,
  parameter int NUM_BYTES = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_base,
  input  logic [ADDR_BITS-1:0] cmd_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  output logic                 ram_we,
  input  logic [7:0]           ram_rdata,
  output logic                 done,
  output logic                 err
);
  localparam int RW = ADDR_BITS + 1;
  localparam logic [RW-1:0] NB = RW'(NUM_BYTES);
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(NUM_BYTES - 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d, ptr_inc;
  logic [RW-1:0] rem_q, rem_d;
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, done_q, done_d, err_q, err_d, last_q, last_d;
  logic accept, base_bad, len_full, load;
  assign cmd_ready = (state_q == IDLE) && !out_valid_q;
  assign accept    = cmd_valid && cmd_ready;
  assign base_bad  = {1'b0, cmd_base} >= NB;
  assign len_full  = (cmd_len == '0) || ({1'b0, cmd_len} > NB);
  assign ptr_inc   = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign load      = (state_q == READ) && (!out_valid_q || out_ready);
  assign ram_addr  = ptr_q;
  assign ram_wdata = in_data;
  assign in_ready  = state_q == WRITE;
  assign ram_we    = (state_q == WRITE) && in_valid;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    last_d      = last_q;
    done_d      = 1'b0;
    if (accept) begin
      ptr_d   = base_bad ? '0 : cmd_base;
      rem_d   = len_full ? NB : {1'b0, cmd_len};
      err_d   = err_q | base_bad;
      state_d = (cmd_op == 2'b01) ? WRITE : (cmd_op == 2'b10) ? READ : IDLE;
    end
    if (ram_we) begin
      ptr_d = ptr_inc;
      rem_d = rem_q - 1'b1;
      if (rem_q == RW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    // last_q marks the final read byte so done waits until it is actually consumed
    if (load) begin
      out_data_d  = ram_rdata;
      out_valid_d = 1'b1;
      ptr_d       = ptr_inc;
      rem_d       = rem_q - 1'b1;
      if (rem_q == RW'(1)) begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (last_q) begin
        done_d = 1'b1;
        last_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_q      <= last_d;
    end
  end
endmodule
